// File: rtl/igniter_pkg.sv
// Shared igniter continuity types and default thresholds (5.6 fixed-point ohms).
// The display formatter uses the same constants.
package igniter_pkg;

  typedef enum logic [1:0] {
    UNKNOWN = 2'd0,
    SHORT   = 2'd1,
    GOOD    = 2'd2,
    OPEN    = 2'd3
  } ign_status_t;

  localparam logic [10:0] ADC_INV_MASK = 11'h7FF;

  localparam int IGN_R_SHORT = 16;
  localparam int IGN_R_OPEN  = 1280;
  localparam int IGN_R_HYST  = 8;

  function automatic logic [10:0] adc_to_mag(input logic [10:0] adc);
    return adc ^ ADC_INV_MASK;
  endfunction

endpackage

// File: rtl/igniter_monitor_r_window_avg.sv
// Decodes ADC resistance codes and box-car averages 2^AVG_LOG2 samples per window.
// avg_next/win_close expose the closing window combinationally so status can update with r_avg.
module r_window_avg
  import igniter_pkg::*;
#(
  parameter int AVG_LOG2 = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [11:0] r_in,
  input  logic        clear,
  output logic        win_close,
  output logic [10:0] avg_next,
  output logic [10:0] r_avg,
  output logic        avg_valid
);

  localparam int SUM_W = 11 + AVG_LOG2;

  logic [SUM_W-1:0]    sum_q, sum_d, sum_inc;
  logic [AVG_LOG2-1:0] cnt_q, cnt_d;
  logic [10:0]         mag;
  logic [10:0]         r_avg_q, r_avg_d;
  logic                avg_valid_q, avg_valid_d;
  logic                unused_r_in_msb;

  // Bit 11 of the ADC word carries no information.
  assign unused_r_in_msb = r_in[11];
  assign mag             = adc_to_mag(r_in[10:0]);
  assign sum_inc         = sum_q + SUM_W'(mag);
  assign win_close       = valid_in && !clear && (cnt_q == '1);
  assign avg_next        = 11'(sum_inc >> AVG_LOG2);

  always_comb begin
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    r_avg_d     = r_avg_q;
    avg_valid_d = win_close;
    if (clear) begin
      sum_d = '0;
      cnt_d = '0;
    end else if (valid_in) begin
      cnt_d = cnt_q + AVG_LOG2'(1);
      sum_d = win_close ? '0 : sum_inc;
      if (win_close) r_avg_d = avg_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q       <= '0;
      cnt_q       <= '0;
      r_avg_q     <= '0;
      avg_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      r_avg_q     <= r_avg_d;
      avg_valid_q <= avg_valid_d;
    end
  end

  assign r_avg     = r_avg_q;
  assign avg_valid = avg_valid_q;

endmodule

// File: rtl/igniter_monitor.sv
// Igniter continuity monitor: classifies window averages with hysteresis, debounces
// the verdict over several windows, and flags the reading stale when samples stop.
module igniter_monitor
  import igniter_pkg::*;
#(
  parameter int AVG_LOG2 = 3,
  parameter int R_SHORT  = IGN_R_SHORT,
  parameter int R_OPEN   = IGN_R_OPEN,
  parameter int R_HYST   = IGN_R_HYST,
  parameter int DEBOUNCE = 3,
  parameter int TIMEOUT  = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [11:0] r_in,
  output logic [10:0] r_avg,
  output logic        avg_valid,
  output logic [1:0]  status,
  output logic        continuity_ok,
  output logic        stale
);

  logic        win_close;
  logic        timeout;
  logic [10:0] avg_next;
  logic [11:0] short_th, open_th;

  ign_status_t status_q, status_d;
  ign_status_t pending_q, pending_d;
  ign_status_t raw;
  logic [1:0]  dcnt_q, dcnt_d, dcnt_upd;
  logic [23:0] idle_q, idle_d;
  logic        stale_q, stale_d;
  logic        cont_q, cont_d;

  r_window_avg #(
    .AVG_LOG2(AVG_LOG2)
  ) u_avg (
    .clk      (clk),
    .reset    (reset),
    .valid_in (valid_in),
    .r_in     (r_in),
    .clear    (timeout),
    .win_close(win_close),
    .avg_next (avg_next),
    .r_avg    (r_avg),
    .avg_valid(avg_valid)
  );

  // A sample arriving on the would-be timeout cycle keeps the reading alive.
  assign timeout = !valid_in && (idle_q == 24'(TIMEOUT - 1));

  // Thresholds widen toward the current state so a marginal reading cannot chatter.
  always_comb begin
    short_th = 12'(R_SHORT) + ((status_q == SHORT) ? 12'(R_HYST) : 12'd0);
    open_th  = 12'(R_OPEN)  - ((status_q == OPEN)  ? 12'(R_HYST) : 12'd0);
    if ({1'b0, avg_next} < short_th)      raw = SHORT;
    else if ({1'b0, avg_next} > open_th)  raw = OPEN;
    else                                  raw = GOOD;
  end

  always_comb begin
    status_d  = status_q;
    pending_d = pending_q;
    dcnt_d    = dcnt_q;
    dcnt_upd  = dcnt_q;
    stale_d   = valid_in ? 1'b0 : stale_q;
    cont_d    = (status_q == GOOD);

    if (valid_in)              idle_d = '0;
    else if (idle_q != '1)     idle_d = idle_q + 24'd1;
    else                       idle_d = idle_q;

    if (win_close) begin
      if (raw == status_q) begin
        dcnt_upd = 2'd0;
      end else if (raw == pending_q) begin
        dcnt_upd = dcnt_q + 2'd1;
      end else begin
        pending_d = raw;
        dcnt_upd  = 2'd1;
      end
      dcnt_d = dcnt_upd;
      if (dcnt_upd == 2'(DEBOUNCE)) begin
        status_d = raw;
        dcnt_d   = 2'd0;
      end
    end

    if (timeout) begin
      stale_d   = 1'b1;
      status_d  = UNKNOWN;
      pending_d = UNKNOWN;
      dcnt_d    = 2'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      status_q  <= UNKNOWN;
      pending_q <= UNKNOWN;
      dcnt_q    <= 2'd0;
      idle_q    <= '0;
      stale_q   <= 1'b1;
      cont_q    <= 1'b0;
    end else begin
      status_q  <= status_d;
      pending_q <= pending_d;
      dcnt_q    <= dcnt_d;
      idle_q    <= idle_d;
      stale_q   <= stale_d;
      cont_q    <= cont_d;
    end
  end

  assign status        = status_q;
  assign continuity_ok = cont_q;
  assign stale         = stale_q;

endmodule
